// File: rtl/pr_sum_sched.sv
// pr_sum_sched
//   Round-robin scheduler in front of a shared 3-stage, 4-operand sum
//   pipeline (a+b, then +c, then +d).
//
//   Each accepted operation carries its requester ID down the pipe. The result
//   returns to the requester that issued it exactly 3 cycles after acceptance.
//   The pipeline has no output backpressure, so it sustains 1 op/cycle.
//
//   Optional feature macro: PR_SCHED_CMP_EN
//     When defined, the block adds port resp_cmp = a*b. The product is formed
//     in S1 and travels alongside the sum. When undefined, the block has no
//     resp_cmp port and no multiplier.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   hold        1 = grant nothing new; in-flight ops keep draining
//   req_valid   per-requester request
//   req_ready   one-hot grant (combinational, may depend on req_valid)
//   req_data    requester i supplies {d,c,b,a} at [i*4W +: 4W]
//   resp_valid  one-hot result strobe, one cycle per result
//   resp_id     requester index of the current result
//   resp_sum    a+b+c+d, W+2 bits (cannot overflow)
//   busy        some pipeline stage holds a valid op
//   issued_cnt  number of accepted operations, wrapping
//   resp_cmp    a*b, aligned with resp_sum (PR_SCHED_CMP_EN only)

module pr_sum_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 hold,
  input  logic [NREQ-1:0]                      req_valid,
  output logic [NREQ-1:0]                      req_ready,
  input  logic [NREQ*4*W-1:0]                  req_data,
  output logic [NREQ-1:0]                      resp_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] resp_id,
  output logic [W+1:0]                         resp_sum,
  output logic                                 busy,
  output logic [CNT_W-1:0]                     issued_cnt
`ifdef PR_SCHED_CMP_EN
  ,
  output logic [2*W-1:0]                       resp_cmp
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]  last_grant;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            fire;
  logic [4*W-1:0]  sel;
  logic [W-1:0]    op_a, op_b, op_c, op_d;

  // Stage registers: a valid bit and an ID tag travel with each stage.
  // The c and d operands are delayed so that each one meets the partial
  // sum in the right stage.
  logic            s1_v;
  logic [IDW-1:0]  s1_id;
  logic [W:0]      s1_ab;
  logic [W-1:0]    s1_c;
  logic [W-1:0]    s1_d;

  logic            s2_v;
  logic [IDW-1:0]  s2_id;
  logic [W+1:0]    s2_abc;
  logic [W-1:0]    s2_d;

`ifdef PR_SCHED_CMP_EN
  logic [2*W-1:0]  s1_p;
  logic [2*W-1:0]  s2_p;
`endif

  // Round-robin search. It starts one past the last requester that actually
  // transferred. The first valid requester found wins. The grant is gated
  // off while hold or reset is high.
  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    fire  = 1'b0;
    idx   = 0;
    if (!hold && !reset) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!fire && req_valid[idx]) begin
          grant[idx] = 1'b1;
          gidx       = IDW'(idx);
          fire       = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;

  assign sel  = req_data[int'(gidx)*4*W +: 4*W];
  assign op_a = sel[W-1:0];
  assign op_b = sel[2*W-1:W];
  assign op_c = sel[3*W-1:2*W];
  assign op_d = sel[4*W-1:3*W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
      issued_cnt <= '0;
      busy       <= 1'b0;
      s1_v       <= 1'b0;
      s1_id      <= '0;
      s1_ab      <= '0;
      s1_c       <= '0;
      s1_d       <= '0;
      s2_v       <= 1'b0;
      s2_id      <= '0;
      s2_abc     <= '0;
      s2_d       <= '0;
      resp_valid <= '0;
      resp_id    <= '0;
      resp_sum   <= '0;
`ifdef PR_SCHED_CMP_EN
      s1_p       <= '0;
      s2_p       <= '0;
      resp_cmp   <= '0;
`endif
    end else begin
      if (fire) begin
        last_grant <= gidx;
        issued_cnt <= issued_cnt + 1'b1;
      end

      // busy reflects the valid bits that this same edge loads.
      busy <= fire | s1_v | s2_v;

      s1_v <= fire;
      if (fire) begin
        s1_id <= gidx;
        s1_ab <= {1'b0, op_a} + {1'b0, op_b};
        s1_c  <= op_c;
        s1_d  <= op_d;
`ifdef PR_SCHED_CMP_EN
        s1_p  <= {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
`endif
      end

      s2_v <= s1_v;
      if (s1_v) begin
        s2_id  <= s1_id;
        s2_abc <= {1'b0, s1_ab} + {2'b00, s1_c};
        s2_d   <= s1_d;
`ifdef PR_SCHED_CMP_EN
        s2_p   <= s1_p;
`endif
      end

      // The result outputs hold their last value between results.
      resp_valid <= '0;
      if (s2_v) begin
        resp_valid[s2_id] <= 1'b1;
        resp_id           <= s2_id;
        resp_sum          <= s2_abc + {2'b00, s2_d};
`ifdef PR_SCHED_CMP_EN
        resp_cmp          <= s2_p;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pr_sum_sched.sv
// tb_pr_sum_sched
//   Randomised and directed stimulus for pr_sum_sched (NREQ=4, W=8).
//   A transaction-level reference model keeps per-requester pending flags, a
//   round-robin pointer and a queue of expected results with due cycles.
//   A second instance with CNT_W=4 shares the same stimulus and exercises
//   counter wrap.

module tb_pr_sum_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  hold  = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*4*W-1:0]   req_data  = '0;

  logic [NREQ-1:0]       req_ready,  req_ready_b;
  logic [NREQ-1:0]       resp_valid, resp_valid_b;
  logic [IDW-1:0]        resp_id,    resp_id_b;
  logic [W+1:0]          resp_sum,   resp_sum_b;
  logic                  busy,       busy_b;
  logic [15:0]           issued_cnt;
  logic [3:0]            issued_cnt_b;
`ifdef PR_SCHED_CMP_EN
  logic [2*W-1:0]        resp_cmp, resp_cmp_b;
`endif

  pr_sum_sched #(.NREQ(NREQ), .W(W), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .busy(busy), .issued_cnt(issued_cnt)
`ifdef PR_SCHED_CMP_EN
    , .resp_cmp(resp_cmp)
`endif
  );

  pr_sum_sched #(.NREQ(NREQ), .W(W), .CNT_W(4)) dut_w4 (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_data(req_data),
    .resp_valid(resp_valid_b), .resp_id(resp_id_b), .resp_sum(resp_sum_b),
    .busy(busy_b), .issued_cnt(issued_cnt_b)
`ifdef PR_SCHED_CMP_EN
    , .resp_cmp(resp_cmp_b)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int id;
    int sum;
    int prod;
  } exp_t;

  exp_t           q[$];
  bit             pend[NREQ];
  logic [4*W-1:0] pdata[NREQ];
  int             last_g;
  int             cnt;
  int             cyc;
  int             n_pass;
  int             n_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int model_grant();
    int i;
    if (hold || reset) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      i = (last_g + k) % NREQ;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [NREQ-1:0] ev;
    bit              hit;
    ev  = '0;
    hit = (q.size() > 0) && (q[0].due == cyc);
    if (hit) ev[q[0].id] = 1'b1;
    check("busy", busy, q.size() > 0);
    check("resp_valid", resp_valid, ev);
    check("resp_valid_w4", resp_valid_b, ev);
    check("busy_w4", busy_b, q.size() > 0);
    check("issued_cnt", issued_cnt, cnt % 65536);
    check("issued_cnt_w4", issued_cnt_b, cnt % 16);
    if (hit) begin
      check("resp_id", resp_id, q[0].id);
      check("resp_sum", resp_sum, q[0].sum);
      check("resp_sum_w4", resp_sum_b, q[0].sum);
`ifdef PR_SCHED_CMP_EN
      check("resp_cmp", resp_cmp, q[0].prod);
`endif
      void'(q.pop_front());
    end
  endtask

  // One clock cycle. The task is entered and left at a falling edge.
  task automatic step(input bit h, input logic [NREQ-1:0] newreq);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0]    a, b, c, d;
    exp_t            e;
    for (int i = 0; i < NREQ; i++)
      if (newreq[i] && !pend[i]) begin
        pend[i]  = 1'b1;
        pdata[i] = $urandom;
      end
    hold = h;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]             = pend[i];
      req_data[i*4*W +: 4*W]   = pdata[i];
    end
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    @(posedge clock);
    cyc++;
    if (g >= 0) begin
      {d, c, b, a} = pdata[g];
      e.due  = cyc + 2;
      e.id   = g;
      e.sum  = int'(a) + int'(b) + int'(c) + int'(d);
      e.prod = int'(a) * int'(b);
      q.push_back(e);
      pend[g] = 1'b0;
      last_g  = g;
      cnt++;
    end
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  // Reset for one cycle. The outputs must clear as soon as reset rises.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    q.delete();
    last_g = NREQ - 1;
    cnt    = 0;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_issued_cnt", issued_cnt, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_sum", resp_sum, 0);
`ifdef PR_SCHED_CMP_EN
    check("rst_resp_cmp", resp_cmp, 0);
`endif
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_chk  = 0;
    cyc    = 0;
    cnt    = 0;
    last_g = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = '0;
    end
    #2 reset = 1'b1;
    @(negedge clock);
    do_reset();

    // Single op from requester 0: {a,b,c,d} = {1,2,3,4}, so the sum is 10.
    repeat (4) step(1'b0, '0);
    pend[0]  = 1'b1;
    pdata[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    step(1'b0, '0);
    repeat (4) step(1'b0, '0);

    // All requesters valid continuously from reset.
    do_reset();
    repeat (12) step(1'b0, 4'hF);
    repeat (4) step(1'b0, '0);

    // Maximum operands.
    for (int i = 0; i < NREQ; i++) begin
      pend[i]  = 1'b1;
      pdata[i] = '1;
    end
    repeat (8) step(1'b0, '0);

    // Three ops in flight, then hold with requester 2 waiting.
    repeat (3) step(1'b0, 4'b1011);
    pend[2] = 1'b1;
    repeat (4) step(1'b1, '0);
    step(1'b0, '0);
    repeat (4) step(1'b0, '0);

    // Reset with two ops in flight.
    do_reset();
    repeat (2) step(1'b0, 4'b0011);
    do_reset();
    repeat (6) step(1'b0, 4'hF);
    repeat (4) step(1'b0, '0);

    // Randomised traffic with random hold.
    repeat (400) step($urandom_range(0, 4) == 0, 4'($urandom));
    repeat (5) step(1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
